// File: rtl/dma_regs_if.sv
// Wishbone slave bundle between the host bus and the DMA register file.
interface dma_regs_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [2:0]  wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        wbs_rty_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );
endinterface

// File: rtl/dma_regs.sv
// DMA register file: host-programmable NDAR/enable/append/int-clear driving
// the descriptor controller, plus read-only controller status.
module dma_regs #(
  parameter logic [28:0] NDAR_RST = 29'h0,
  parameter int          STATE_W  = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  dma_regs_if.slave          wb,
  output logic [28:0]        ndar,
  output logic               ndar_dirty,
  input  logic               ndar_dirty_clear,
  output logic               append,
  input  logic               append_clear,
  output logic               enable,
  output logic               wb_int_clear,
  input  logic               wb_int_i,
  input  logic               busy,
  input  logic [31:0]        dar,
  input  logic [7:0]         csr,
  input  logic [STATE_W-1:0] ctrl_state
);

  localparam logic [2:0] ADR_CCR  = 3'd0;
  localparam logic [2:0] ADR_STAT = 3'd1;
  localparam logic [2:0] ADR_NDAR = 3'd2;
  localparam logic [2:0] ADR_DAR  = 3'd3;
  localparam logic [2:0] ADR_DBG  = 3'd4;

  logic        ack_n;
  logic        wr_commit;
  logic        ccr_wr;
  logic        ndar_wr;
  logic [31:0] rd_data;

  assign ack_n     = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o;
  assign wr_commit = ack_n & wb.wbs_we_i;
  assign ccr_wr    = wr_commit & (wb.wbs_adr_i == ADR_CCR) & wb.wbs_sel_i[0];
  assign ndar_wr   = wr_commit & (wb.wbs_adr_i == ADR_NDAR);

  assign wb.wbs_err_o = 1'b0;
  assign wb.wbs_rty_o = 1'b0;

  // Read mux sampled from current register state; unmapped words read zero.
  always_comb begin
    rd_data = '0;
    case (wb.wbs_adr_i)
      ADR_CCR:  rd_data = {30'd0, append, enable};
      ADR_STAT: rd_data = {16'd0, csr, 4'd0, append, ndar_dirty, wb_int_i, busy};
      ADR_NDAR: rd_data = {ndar, 3'b000};
      ADR_DAR:  rd_data = dar;
      ADR_DBG:  rd_data = 32'(ctrl_state);
      default:  rd_data = '0;
    endcase
  end

  // Single-cycle ack per strobe; read data is registered alongside ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
    end else begin
      wb.wbs_ack_o <= ack_n;
      wb.wbs_dat_o <= (ack_n && !wb.wbs_we_i) ? rd_data : 32'd0;
    end
  end

  // NDAR byte lanes map onto ndar[31:3]; byte 0 contributes only bits [7:3].
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ndar <= NDAR_RST;
    end else if (ndar_wr) begin
      if (wb.wbs_sel_i[0]) ndar[4:0]   <= wb.wbs_dat_i[7:3];
      if (wb.wbs_sel_i[1]) ndar[12:5]  <= wb.wbs_dat_i[15:8];
      if (wb.wbs_sel_i[2]) ndar[20:13] <= wb.wbs_dat_i[23:16];
      if (wb.wbs_sel_i[3]) ndar[28:21] <= wb.wbs_dat_i[31:24];
    end
  end

  // Dirty flag handshake with ctrl; a fresh write beats a same-cycle take.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ndar_dirty <= 1'b0;
    end else if (ndar_wr && (wb.wbs_sel_i != 4'd0)) begin
      ndar_dirty <= 1'b1;
    end else if (ndar_dirty_clear) begin
      ndar_dirty <= 1'b0;
    end
  end

  // Append request handshake; stays pending across enable changes.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      append <= 1'b0;
    end else if (ccr_wr && wb.wbs_dat_i[1]) begin
      append <= 1'b1;
    end else if (append_clear) begin
      append <= 1'b0;
    end
  end

  // Enable bit and the one-shot interrupt-clear pulse from CCR writes.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      enable       <= 1'b0;
      wb_int_clear <= 1'b0;
    end else begin
      if (ccr_wr) enable <= wb.wbs_dat_i[0];
      wb_int_clear <= ccr_wr & wb.wbs_dat_i[2];
    end
  end

endmodule

// File: tb/tb_dma_regs.sv
// Self-checking bench for dma_regs: table of bus vectors plus hand sequences,
// read data checked through a scoreboard queue popped on each ack.
module tb_dma_regs;

  logic        clk;
  logic        rst_n;
  logic [28:0] ndar;
  logic        ndar_dirty;
  logic        ndar_dirty_clear;
  logic        append;
  logic        append_clear;
  logic        enable;
  logic        wb_int_clear;
  logic        wb_int_i;
  logic        busy;
  logic [31:0] dar;
  logic [7:0]  csr;
  logic [7:0]  ctrl_state;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] exp;
    string       name;
  } sb_entry_t;

  sb_entry_t sb[$];

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    bit          clr_before;
    logic [31:0] exp_rd;
    logic [28:0] exp_ndar;
    logic        exp_dirty;
    string       name;
  } vec_t;

  dma_regs_if wb ();

  dma_regs #(.NDAR_RST(29'h0), .STATE_W(8)) dut (
    .wb_clk_i        (clk),
    .wb_rst_n        (rst_n),
    .wb              (wb.slave),
    .ndar            (ndar),
    .ndar_dirty      (ndar_dirty),
    .ndar_dirty_clear(ndar_dirty_clear),
    .append          (append),
    .append_clear    (append_clear),
    .enable          (enable),
    .wb_int_clear    (wb_int_clear),
    .wb_int_i        (wb_int_i),
    .busy            (busy),
    .dar             (dar),
    .csr             (csr),
    .ctrl_state      (ctrl_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every ack must match a queued transaction.
  always @(negedge clk) begin
    if (wb.wbs_ack_o === 1'b1) begin
      checkOutput("err_rty", {30'd0, wb.wbs_err_o, wb.wbs_rty_o}, 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_ack", 32'd1, 32'd0);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        if (e.is_read) checkOutput(e.name, wb.wbs_dat_o, e.exp);
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [2:0] adr, input logic [3:0] sel,
                               input logic [31:0] dat, input logic [31:0] exp_rd, input string name);
    sb_entry_t e;
    int cycles;
    bit got;
    e.is_read = !we;
    e.exp     = exp_rd;
    e.name    = name;
    @(posedge clk);
    #1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_sel_i = sel;
    wb.wbs_dat_i = dat;
    sb.push_back(e);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 8) begin
      @(posedge clk);
      #1;
      cycles++;
      if (wb.wbs_ack_o === 1'b1) got = 1'b1;
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    if (!got) begin
      checkOutput({name, "_ack_timeout"}, 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_back());
    end else begin
      checkOutput({name, "_ack_latency"}, 32'(cycles), 32'd1);
    end
  endtask

  task automatic pulseDirtyClear();
    @(posedge clk);
    #1 ndar_dirty_clear = 1'b1;
    @(posedge clk);
    #1 ndar_dirty_clear = 1'b0;
  endtask

  task automatic pulseAppendClear();
    @(posedge clk);
    #1 append_clear = 1'b1;
    @(posedge clk);
    #1 append_clear = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;

    rst_n            = 1'b0;
    ndar_dirty_clear = 1'b0;
    append_clear     = 1'b0;
    wb_int_i         = 1'b0;
    busy             = 1'b0;
    dar              = 32'd0;
    csr              = 8'd0;
    ctrl_state       = 8'd0;
    wb.wbs_cyc_i     = 1'b1;
    wb.wbs_stb_i     = 1'b1;
    wb.wbs_we_i      = 1'b1;
    wb.wbs_adr_i     = 3'd0;
    wb.wbs_sel_i     = 4'hF;
    wb.wbs_dat_i     = 32'h7;

    // Reset held with a live strobe: nothing may move.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
    checkOutput("rst_ndar", {3'd0, ndar}, 32'd0);
    checkOutput("rst_flags", {27'd0, ndar_dirty, append, enable, wb_int_clear, wb.wbs_dat_o != 0}, 32'd0);
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    #2 rst_n = 1'b1;

    // Table vectors: NDAR write/readback, byte select, unmapped/RO addresses.
    vecs.push_back('{1'b1, 3'd2, 4'hF, 32'h1234_5678, 1'b0, 32'h0,         29'h0246_8ACF, 1'b1, "ndar_wr"});
    vecs.push_back('{1'b0, 3'd2, 4'hF, 32'h0,         1'b0, 32'h1234_5678, 29'h0246_8ACF, 1'b1, "ndar_rd"});
    vecs.push_back('{1'b0, 3'd1, 4'hF, 32'h0,         1'b1, 32'h0,         29'h0246_8ACF, 1'b0, "stat_after_clr"});
    vecs.push_back('{1'b1, 3'd2, 4'hF, 32'h0,         1'b0, 32'h0,         29'h0,         1'b1, "ndar_zero"});
    vecs.push_back('{1'b1, 3'd2, 4'h2, 32'hFFFF_FFFF, 1'b1, 32'h0,         29'h1FE0,      1'b1, "ndar_sel1"});
    vecs.push_back('{1'b0, 3'd2, 4'hF, 32'h0,         1'b0, 32'h0000_FF00, 29'h1FE0,      1'b1, "ndar_sel1_rd"});
    vecs.push_back('{1'b1, 3'd6, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0,         29'h1FE0,      1'b1, "unmapped_wr"});
    vecs.push_back('{1'b0, 3'd6, 4'hF, 32'h0,         1'b0, 32'h0,         29'h1FE0,      1'b1, "unmapped_rd6"});
    vecs.push_back('{1'b1, 3'd2, 4'h0, 32'hFFFF_FFFF, 1'b1, 32'h0,         29'h1FE0,      1'b0, "ndar_sel0"});
    vecs.push_back('{1'b0, 3'd5, 4'hF, 32'h0,         1'b0, 32'h0,         29'h1FE0,      1'b0, "unmapped_rd5"});
    vecs.push_back('{1'b0, 3'd7, 4'hF, 32'h0,         1'b0, 32'h0,         29'h1FE0,      1'b0, "unmapped_rd7"});
    vecs.push_back('{1'b1, 3'd1, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0,         29'h1FE0,      1'b0, "stat_wr"});
    vecs.push_back('{1'b0, 3'd1, 4'hF, 32'h0,         1'b0, 32'h0,         29'h1FE0,      1'b0, "stat_rd"});
    vecs.push_back('{1'b0, 3'd0, 4'hF, 32'h0,         1'b0, 32'h0,         29'h1FE0,      1'b0, "ccr_rd0"});

    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.clr_before) pulseDirtyClear();
      applyStimulus(v.we, v.adr, v.sel, v.dat, v.exp_rd, v.name);
      checkOutput({v.name, "_ndar"}, {3'd0, ndar}, {3'd0, v.exp_ndar});
      checkOutput({v.name, "_dirty"}, {31'd0, ndar_dirty}, {31'd0, v.exp_dirty});
      checkOutput({v.name, "_enable"}, {31'd0, enable}, 32'd0);
    end

    // Dirty set, then ctrl takes it: clears one cycle after the pulse.
    applyStimulus(1'b1, 3'd2, 4'hF, 32'h0000_0100, 32'h0, "ndar_wr2");
    checkOutput("dirty_set", {31'd0, ndar_dirty}, 32'd1);
    pulseDirtyClear();
    checkOutput("dirty_cleared", {31'd0, ndar_dirty}, 32'd0);

    // Collision: clear held across the commit edge, set must win.
    ndar_dirty_clear = 1'b1;
    applyStimulus(1'b1, 3'd2, 4'hF, 32'h0000_0200, 32'h0, "ndar_collide");
    ndar_dirty_clear = 1'b0;
    checkOutput("dirty_collision", {31'd0, ndar_dirty}, 32'd1);
    checkOutput("ndar_collide_val", {3'd0, ndar}, 32'h40);

    // CCR write of 0x7: enable, append, and a single-cycle int clear.
    checkOutput("intclr_idle", {31'd0, wb_int_clear}, 32'd0);
    applyStimulus(1'b1, 3'd0, 4'hF, 32'h7, 32'h0, "ccr_wr7");
    checkOutput("ccr_enable", {31'd0, enable}, 32'd1);
    checkOutput("ccr_append", {31'd0, append}, 32'd1);
    checkOutput("intclr_pulse", {31'd0, wb_int_clear}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("intclr_one_cycle", {31'd0, wb_int_clear}, 32'd0);
    applyStimulus(1'b0, 3'd0, 4'hF, 32'h0, 32'h3, "ccr_rd3");
    pulseAppendClear();
    checkOutput("append_cleared", {31'd0, append}, 32'd0);
    applyStimulus(1'b0, 3'd0, 4'hF, 32'h0, 32'h1, "ccr_rd1");

    // Append collision: clear held across the commit edge, set must win.
    append_clear = 1'b1;
    applyStimulus(1'b1, 3'd0, 4'h1, 32'h3, 32'h0, "append_collide");
    append_clear = 1'b0;
    checkOutput("append_collision", {31'd0, append}, 32'd1);

    // Disabling the channel leaves pending flags untouched.
    applyStimulus(1'b1, 3'd0, 4'h1, 32'h0, 32'h0, "ccr_disable");
    checkOutput("disable_enable", {31'd0, enable}, 32'd0);
    checkOutput("disable_keeps_append", {31'd0, append}, 32'd1);
    checkOutput("disable_keeps_dirty", {31'd0, ndar_dirty}, 32'd1);

    // Controller status readback with both flags drained.
    pulseAppendClear();
    pulseDirtyClear();
    busy       = 1'b1;
    wb_int_i   = 1'b1;
    csr        = 8'hA5;
    dar        = 32'h8000_0040;
    ctrl_state = 8'd4;
    applyStimulus(1'b0, 3'd1, 4'hF, 32'h0, 32'h0000_A503, "stat_rd_live");
    applyStimulus(1'b0, 3'd3, 4'hF, 32'h0, 32'h8000_0040, "dar_rd");
    applyStimulus(1'b0, 3'd4, 4'hF, 32'h0, 32'h0000_0004, "dbg_rd");

    // NDAR write while busy is accepted.
    applyStimulus(1'b1, 3'd2, 4'hF, 32'hABCD_EF08, 32'h0, "ndar_wr_busy");
    checkOutput("busy_ndar", {ndar, 3'b000}, 32'hABCD_EF08);
    checkOutput("busy_dirty", {31'd0, ndar_dirty}, 32'd1);
    applyStimulus(1'b0, 3'd1, 4'hF, 32'h0, 32'h0000_A507, "stat_rd_dirty");

    // Reset right after an int-clear commit: ack and pulse vanish, no pulse later.
    @(posedge clk);
    #1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_adr_i = 3'd0;
    wb.wbs_sel_i = 4'h1;
    wb.wbs_dat_i = 32'h5;
    @(posedge clk);
    #1;
    checkOutput("midrst_pre_pulse", {31'd0, wb_int_clear}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
    checkOutput("midrst_flags", {28'd0, ndar_dirty, append, enable, wb_int_clear}, 32'd0);
    checkOutput("midrst_ndar", {3'd0, ndar}, 32'd0);
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput("postrst_quiet", {30'd0, wb_int_clear, wb.wbs_ack_o}, 32'd0);
    end
    applyStimulus(1'b0, 3'd0, 4'hF, 32'h0, 32'h0, "postrst_ccr");

    repeat (2) @(posedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
